sy_ppl_ras: RTL and testbench

//  Return address stack for the fetch stage. It consumes the quick-decode classification
//  (qdec_type_e) and the fetch vaddr of each predecoded instruction.
//  - CALL_JAL / CALL_JALR: push the link address.
//  - RET: pop, and supply the predicted return target to the fetch redirect mux.
//  A commit-side pointer/count copy restores the speculative stack position on pipeline flush.

---
 rtl/sy_pkg.sv | 28 ++
 rtl/sy_ppl_ras_cnt.sv | 57 +++++
 rtl/sy_ppl_ras.sv | 88 ++++++++
 tb/tb_sy_ppl_ras.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sy_pkg.sv
// Shared fetch/predecode types and constants.
// Includes return-address-stack sizing.
package sy_pkg;

  typedef enum logic [2:0] {
    NORMAL,
    BRANCH,
    JUMP,
    JALR,
    CALL_JAL,
    CALL_JALR,
    RET
  } qdec_type_e;

  localparam int AWTH      = 32;
  localparam int RAS_DEPTH = 8;

  typedef logic [$clog2(RAS_DEPTH)-1:0] ras_ptr_t;

  function automatic logic qdec_is_call(qdec_type_e t);
    return (t == CALL_JAL) || (t == CALL_JALR);
  endfunction

  function automatic logic qdec_is_ret(qdec_type_e t);
    return t == RET;
  endfunction

endpackage

// File: rtl/sy_ppl_ras_cnt.sv
// RAS top-of-stack pointer with saturating occupancy count.
// Next-state values are exported for same-cycle forwarding.
module sy_ppl_ras_cnt
  import sy_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          load_i,
  input  logic [PW-1:0] ld_ptr_i,
  input  logic [CW-1:0] ld_cnt_i,
  output logic [PW-1:0] ptr_o,
  output logic [CW-1:0] cnt_o,
  output logic [PW-1:0] ptr_d_o,
  output logic [CW-1:0] cnt_d_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      ptr_d = ld_ptr_i;
      cnt_d = ld_cnt_i;
    end else if (push_i) begin
      ptr_d = ptr_q + PW'(1);
      // When full the oldest slot is overwritten; count stays saturated.
      if (cnt_q != CW'(DEPTH)) cnt_d = cnt_q + CW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign cnt_o   = cnt_q;
  assign ptr_d_o = ptr_d;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/sy_ppl_ras.sv
// Return address stack for fetch: speculative push/pop,
// restored from a commit-side pointer copy on flush.
module sy_ppl_ras
  import sy_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  input  qdec_type_e       instr_type_i,
  input  logic             instr_is_c_i,
  input  logic [AWTH-1:0]  vaddr_i,
  output logic             ret_hit_o,
  output logic [AWTH-1:0]  ret_target_o,
  input  logic             commit_valid_i,
  input  qdec_type_e       commit_type_i,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AWTH-1:0] ent_q [DEPTH];

  logic [PW-1:0] spc_ptr_q, spc_ptr_d;
  logic [CW-1:0] spc_cnt_q, spc_cnt_d;
  logic [PW-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [CW-1:0] cmt_cnt_q, cmt_cnt_d;

  logic f_push, f_pop, c_push, c_pop;
  logic [AWTH-1:0] link;

  // Flush wins over the fetch-side op in the same cycle.
  assign f_push = valid_i & qdec_is_call(instr_type_i) & ~flush_i;
  assign f_pop  = valid_i & qdec_is_ret(instr_type_i) & ~flush_i;
  assign c_push = commit_valid_i & qdec_is_call(commit_type_i);
  assign c_pop  = commit_valid_i & qdec_is_ret(commit_type_i);

  assign link = vaddr_i + (instr_is_c_i ? AWTH'(2) : AWTH'(4));

  sy_ppl_ras_cnt #(.DEPTH(DEPTH)) u_spc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (f_push),
    .pop_i    (f_pop),
    .load_i   (flush_i),
    .ld_ptr_i (cmt_ptr_d),
    .ld_cnt_i (cmt_cnt_d),
    .ptr_o    (spc_ptr_q),
    .cnt_o    (spc_cnt_q),
    .ptr_d_o  (spc_ptr_d),
    .cnt_d_o  (spc_cnt_d)
  );

  sy_ppl_ras_cnt #(.DEPTH(DEPTH)) u_cmt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (c_push),
    .pop_i    (c_pop),
    .load_i   (1'b0),
    .ld_ptr_i ('0),
    .ld_cnt_i ('0),
    .ptr_o    (cmt_ptr_q),
    .cnt_o    (cmt_cnt_q),
    .ptr_d_o  (cmt_ptr_d),
    .cnt_d_o  (cmt_cnt_d)
  );

  logic unused_cnt;
  assign unused_cnt = ^{cmt_ptr_q, cmt_cnt_q, spc_ptr_d, spc_cnt_d};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (f_push) begin
      ent_q[spc_ptr_q] <= link;
    end
  end

  assign empty_o      = (spc_cnt_q == '0);
  assign full_o       = (spc_cnt_q == CW'(DEPTH));
  assign ret_target_o = ent_q[spc_ptr_q - PW'(1)];
  assign ret_hit_o    = valid_i & qdec_is_ret(instr_type_i) & ~empty_o;

endmodule

// File: tb/tb_sy_ppl_ras.sv
// Directed bench for sy_ppl_ras with a scoreboard of
// expected RET predictions.
module tb_sy_ppl_ras;
  import sy_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            valid;
  qdec_type_e      itype;
  logic            is_c;
  logic [AWTH-1:0] vaddr;
  logic            hit;
  logic [AWTH-1:0] tgt;
  logic            cvalid;
  qdec_type_e      ctype;
  logic            empty;
  logic            full;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic            hit;
    logic            chk_tgt;
    logic [AWTH-1:0] tgt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sy_ppl_ras dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .valid_i        (valid),
    .instr_type_i   (itype),
    .instr_is_c_i   (is_c),
    .vaddr_i        (vaddr),
    .ret_hit_o      (hit),
    .ret_target_o   (tgt),
    .commit_valid_i (cvalid),
    .commit_type_i  (ctype),
    .empty_o        (empty),
    .full_o         (full)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    valid  = 1'b0;
    itype  = NORMAL;
    is_c   = 1'b0;
    vaddr  = '0;
    flush  = 1'b0;
    cvalid = 1'b0;
    ctype  = NORMAL;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic call(input qdec_type_e t, input logic [AWTH-1:0] a,
                      input logic c);
    valid = 1'b1;
    itype = t;
    vaddr = a;
    is_c  = c;
    tick();
  endtask

  task automatic commit(input qdec_type_e t);
    cvalid = 1'b1;
    ctype  = t;
    tick();
  endtask

  task automatic ret(input logic h, input logic ct,
                     input logic [AWTH-1:0] a);
    exp_t e;
    valid = 1'b1;
    itype = RET;
    sb.push_back('{hit: h, chk_tgt: ct, tgt: a});
    #1;
    e = sb.pop_front();
    chk("ret_hit", 64'(hit), 64'(e.hit));
    if (e.chk_tgt) chk("ret_target", 64'(tgt), 64'(e.tgt));
    tick();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_target", 64'(tgt), 64'd0);
    valid = 1'b1;
    itype = RET;
    #1;
    chk("rst_hit", 64'(hit), 64'd0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_empty", 64'(empty), 64'd1);
    chk("init_target", 64'(tgt), 64'd0);
    rst_n = 1'b1;
    tick();

    // single call/return
    call(CALL_JAL, 32'h1000, 1'b0);
    chk("t2_empty", 64'(empty), 64'd0);
    ret(1'b1, 1'b1, 32'h1004);
    chk("t2_empty_after", 64'(empty), 64'd1);

    // nested, mixed compressed
    call(CALL_JALR, 32'h2000, 1'b1);
    call(CALL_JAL, 32'h3000, 1'b0);
    ret(1'b1, 1'b1, 32'h3004);
    ret(1'b1, 1'b1, 32'h2002);
    chk("t3_empty", 64'(empty), 64'd1);

    // mid-run reset discards pending stack contents
    call(CALL_JAL, 32'h7000, 1'b0);
    call(CALL_JAL, 32'h7100, 1'b0);
    do_reset();

    // overflow past depth
    for (int k = 1; k <= 9; k++) begin
      call(CALL_JAL, 32'(k * 32'h100), 1'b0);
      if (k == 7) chk("t4_not_full", 64'(full), 64'd0);
      if (k == 8) chk("t4_full8", 64'(full), 64'd1);
    end
    chk("t4_full9", 64'(full), 64'd1);
    for (int k = 9; k >= 2; k--)
      ret(1'b1, 1'b1, 32'(k * 32'h100 + 4));
    chk("t4_empty", 64'(empty), 64'd1);
    ret(1'b0, 1'b0, '0);
    do_reset();

    // flush restores committed position
    call(CALL_JAL, 32'h1000, 1'b0);
    commit(CALL_JAL);
    call(CALL_JAL, 32'h2000, 1'b0);
    call(CALL_JAL, 32'h3000, 1'b0);
    chk("t5_tgt_pre", 64'(tgt), 64'h3004);
    flush = 1'b1;
    tick();
    chk("t5_empty", 64'(empty), 64'd0);
    chk("t5_tgt", 64'(tgt), 64'h1004);
    ret(1'b1, 1'b1, 32'h1004);
    chk("t5_empty_after", 64'(empty), 64'd1);

    // flush + push + commit pop in one cycle
    call(CALL_JAL, 32'h4000, 1'b0);
    call(CALL_JAL, 32'h5000, 1'b0);
    commit(CALL_JAL);
    flush  = 1'b1;
    valid  = 1'b1;
    itype  = CALL_JAL;
    vaddr  = 32'h6000;
    cvalid = 1'b1;
    ctype  = RET;
    tick();
    chk("t6_empty", 64'(empty), 64'd0);
    chk("t6_tgt", 64'(tgt), 64'h4004);
    ret(1'b1, 1'b1, 32'h4004);
    chk("t6_empty_after", 64'(empty), 64'd1);
    ret(1'b0, 1'b0, '0);

    // non-call types leave the stack alone
    call(CALL_JAL, 32'h8000, 1'b1);
    call(JALR, 32'h9000, 1'b0);
    call(JUMP, 32'h9100, 1'b0);
    call(BRANCH, 32'h9200, 1'b0);
    ret(1'b1, 1'b1, 32'h8002);
    chk("t7_empty", 64'(empty), 64'd1);

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0",
               sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
